plru_way_select: RTL
====================

// Module: plru_way_select
// PURPOSE
//   Replacement/way-select stage for the 8-way set-associative cache. For each lookup it
//   decides which way to read or fill: the hit way, the lowest invalid way, or the tree-PLRU
//   victim. OUT_WAY drives the way-data Mux8 IN_ADDR directly downstream. Keeps one 7-bit
//   PLRU tree per set and updates it on every access.
// PARAMETERS
//   SETS      16  number of cache sets; must equal 2**SET_BITS
//   SET_BITS  4   width of the set index
// PORTS
//   IN_CLK      in   1         clock, all state changes on rising edge
//   IN_RST      in   1         reset, asynchronous, active-high
//   IN_REQ      in   1         lookup request; sampled only when OUT_BUSY=0 and FSM in IDLE
//   IN_SET      in   SET_BITS  set index of the lookup
//   IN_HIT      in   1         tag compare hit for this lookup
//   IN_HIT_WAY  in   3         hitting way index (meaningful when IN_HIT=1)
//   IN_VALID    in   8         valid bits of the 8 ways in IN_SET (bit n = way n)
//   IN_FLUSH    in   1         clear all PLRU trees; sampled in IDLE, priority over IN_REQ
//   OUT_BUSY    out  1         1 in CALC, WRITE, FLUSH; new requests ignored while 1
//   OUT_DONE    out  1         one-cycle pulse: OUT_WAY/OUT_VICTIM valid for this request
//   OUT_WAY     out  3         selected way, registered, held until next OUT_DONE
//   OUT_VICTIM  out  1         1 = miss (way is a fill target), 0 = hit; held with OUT_WAY
// BEHAVIOUR
//   Reset: FSM=IDLE; all PLRU trees=7'b0; flush counter=0; OUT_BUSY/OUT_DONE/OUT_WAY/
//     OUT_VICTIM=0. Reset mid-operation aborts the request; no OUT_DONE is issued.
//   Tree bits b[6:0]: b0 root (0=ways 0-3, 1=ways 4-7); b1 for 0-3 (0=0-1, 1=2-3);
//     b2 for 4-7 (0=4-5, 1=6-7); b3..b6 leaves for pairs 0-1,2-3,4-5,6-7 (0=even, 1=odd).
//   FSM IDLE: IN_FLUSH=1 -> FLUSH. Else IN_REQ=1 -> latch IN_SET, IN_HIT, IN_HIT_WAY,
//     IN_VALID -> CALC. IN_REQ while OUT_BUSY=1 is dropped (no queue); requester waits.
//   CALC: way = IN_HIT ? IN_HIT_WAY : (|~IN_VALID) ? lowest-index invalid way :
//     PLRU walk of plru[set]. Register into OUT_WAY and set OUT_VICTIM=~hit. -> WRITE.
//   WRITE: plru[set] path bits point away from way w: b0=~w[2]; b[1+w[2]]=~w[1];
//     b[3+w[2:1]]=~w[0]; other bits unchanged. OUT_DONE=1 this cycle only. -> IDLE.
//   Latency: REQ sampled at edge k; OUT_DONE high in the cycle after edge k+2; next REQ
//     is accepted at edge k+3 at the earliest. Hit takes precedence over IN_VALID.
//   FLUSH: counter 0..SETS-1 clears one tree per cycle (SETS cycles), then IDLE with
//     counter=0. No OUT_DONE for flush. OUT_WAY/OUT_VICTIM keep their last values.
//   PLRU array has one write port (WRITE or FLUSH); reads are combinational in CALC.
// TESTING
//   1) Reset, REQ set 3, HIT=0, VALID=8'hFF -> OUT_WAY=0, VICTIM=1, DONE 2 edges after
//      REQ; plru[3]=7'b0001011.
//   2) From reset, 8 back-to-back full misses to set 5 -> ways 0,4,2,6,1,5,3,7 in order.
//   3) From reset, hit way 5 on set 1 -> WAY=5, VICTIM=0; then full miss set 1 -> WAY=0.
//   4) Miss, VALID=8'b1110_1011, any PLRU state -> WAY=2, VICTIM=1.
//   5) Update several sets, pulse FLUSH with REQ held -> BUSY for 16 cycles, REQ ignored,
//      no DONE; then full miss on each touched set -> WAY=0.
//   6) Assert IN_RST during CALC -> BUSY/DONE/WAY/VICTIM=0 at once; no DONE after release;
//      next full miss -> WAY=0.

Source files
------------

// File: rtl/plru_way_select_if.sv
// Request/response bundle between the cache lookup pipeline and the way-select stage.
interface plru_way_select_if #(
    parameter int unsigned SET_BITS = 4
) ();
    logic                req;
    logic [SET_BITS-1:0] set;
    logic                hit;
    logic [2:0]          hit_way;
    logic [7:0]          valid;
    logic                flush;
    logic                busy;
    logic                done;
    logic [2:0]          way;
    logic                victim;

    modport master (
        output req, set, hit, hit_way, valid, flush,
        input  busy, done, way, victim
    );

    modport slave (
        input  req, set, hit, hit_way, valid, flush,
        output busy, done, way, victim
    );
endinterface

// File: rtl/plru_way_select.sv
// Way-select stage for an 8-way cache: picks the hit way, the lowest invalid way,
// or the tree-PLRU victim, and keeps one 7-bit PLRU tree per set.
// Tree bits: b0 root, b1/b2 halves, b3..b6 leaf pairs; each bit points at the
// side to replace next (0 = lower-numbered ways).
module plru_way_select #(
    parameter int unsigned SETS     = 16,
    parameter int unsigned SET_BITS = 4
) (
    input logic               clk,
    input logic               rst,
    plru_way_select_if.slave  bus
);

    typedef enum logic [1:0] {StIdle, StCalc, StWrite, StFlush} state_e;

    state_e              state_q;
    logic [6:0]          plru_q [SETS];
    logic [SET_BITS-1:0] set_q;
    logic [SET_BITS-1:0] flush_cnt_q;
    logic                hit_q;
    logic [2:0]          hit_way_q;
    logic [7:0]          valid_q;
    logic                busy_q;
    logic                done_q;
    logic [2:0]          way_q;
    logic                victim_q;

    logic [6:0] cur_tree;
    logic [6:0] upd_tree;
    logic [2:0] plru_way;
    logic [2:0] free_way;
    logic [2:0] sel_way;

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.way    = way_q;
    assign bus.victim = victim_q;

    // Way choice for the latched request: hit, then lowest invalid, then PLRU walk.
    always_comb begin
        cur_tree = plru_q[set_q];
        if (!cur_tree[0]) begin
            plru_way = {1'b0, cur_tree[1], (cur_tree[1] ? cur_tree[4] : cur_tree[3])};
        end else begin
            plru_way = {1'b1, cur_tree[2], (cur_tree[2] ? cur_tree[6] : cur_tree[5])};
        end
        free_way = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (!valid_q[i]) begin
                free_way = 3'(i);
            end
        end
        if (hit_q) begin
            sel_way = hit_way_q;
        end else if (|(~valid_q)) begin
            sel_way = free_way;
        end else begin
            sel_way = plru_way;
        end
    end

    // Tree after touching way_q: every node on its path points away from it.
    always_comb begin
        upd_tree    = cur_tree;
        upd_tree[0] = ~way_q[2];
        if (way_q[2]) begin
            upd_tree[2] = ~way_q[1];
        end else begin
            upd_tree[1] = ~way_q[1];
        end
        upd_tree[3'd3 + {1'b0, way_q[2:1]}] = ~way_q[0];
    end

    // Control FSM, PLRU array write port and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            set_q       <= '0;
            flush_cnt_q <= '0;
            hit_q       <= 1'b0;
            hit_way_q   <= 3'd0;
            valid_q     <= 8'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            way_q       <= 3'd0;
            victim_q    <= 1'b0;
            for (int i = 0; i < int'(SETS); i++) begin
                plru_q[i] <= 7'd0;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    done_q <= 1'b0;
                    if (bus.flush) begin
                        flush_cnt_q <= '0;
                        busy_q      <= 1'b1;
                        state_q     <= StFlush;
                    end else if (bus.req) begin
                        set_q     <= bus.set;
                        hit_q     <= bus.hit;
                        hit_way_q <= bus.hit_way;
                        valid_q   <= bus.valid;
                        busy_q    <= 1'b1;
                        state_q   <= StCalc;
                    end
                end
                StCalc: begin
                    way_q    <= sel_way;
                    victim_q <= ~hit_q;
                    state_q  <= StWrite;
                end
                StWrite: begin
                    plru_q[set_q] <= upd_tree;
                    done_q        <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= StIdle;
                end
                StFlush: begin
                    plru_q[flush_cnt_q] <= 7'd0;
                    if (flush_cnt_q == SET_BITS'(SETS - 1)) begin
                        flush_cnt_q <= '0;
                        busy_q      <= 1'b0;
                        state_q     <= StIdle;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
